// File: rtl/ex_muldiv_unit.sv
// Multi-cycle multiply / multiply-accumulate / divide engine for the execute stage.
// Holds the pipeline while working and returns a HI/LO pair with a one-cycle write strobe.
module ex_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [2:0]         op_i,
  input  logic [WIDTH-1:0]   opa_i,
  input  logic [WIDTH-1:0]   opb_i,
  input  logic [2*WIDTH-1:0] hilo_i,
  input  logic               annul_i,
  output logic               stallreq_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               whilo_o,
  output logic [WIDTH-1:0]   hi_o,
  output logic [WIDTH-1:0]   lo_o,
  output logic               div_by_zero_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_ACC, S_DIV, S_DONE} state_t;

  state_t             r_state, w_next;
  logic [2:0]         r_op;
  logic [WIDTH-1:0]   r_a, r_b, r_rem, r_quo, r_hi, r_lo;
  logic [2*WIDTH-1:0] r_hilo, r_prod;
  logic [CW-1:0]      r_cnt;
  logic               r_dbz;

  logic               w_accept, w_in_div, w_in_dbz, w_last;
  logic               w_a_neg, w_b_neg;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_in_a_mag;
  logic [2*WIDTH-1:0] w_prod_mag, w_prod, w_acc;
  logic [WIDTH:0]     w_shift, w_diff;
  logic [WIDTH-1:0]   w_rem_nx, w_quo_nx, w_rem_fix, w_quo_fix;

  assign w_accept   = start_i & ~annul_i;
  assign w_in_div   = (op_i[2:1] == 2'b11);
  assign w_in_dbz   = (opb_i == '0);
  assign w_in_a_mag = (~op_i[0] & opa_i[WIDTH-1]) ? -opa_i : opa_i;
  assign w_last     = (r_cnt == CW'(WIDTH-1));

  // op[0]==0 selects the signed flavour of every operation.
  assign w_a_neg    = ~r_op[0] & r_a[WIDTH-1];
  assign w_b_neg    = ~r_op[0] & r_b[WIDTH-1];
  assign w_a_mag    = w_a_neg ? -r_a : r_a;
  assign w_b_mag    = w_b_neg ? -r_b : r_b;
  assign w_prod_mag = {{WIDTH{1'b0}}, w_a_mag} * {{WIDTH{1'b0}}, w_b_mag};
  assign w_prod     = (w_a_neg ^ w_b_neg) ? -w_prod_mag : w_prod_mag;
  assign w_acc      = (r_op[2:1] == 2'b10) ? (r_hilo - r_prod) : (r_hilo + r_prod);

  // Restoring step: the dividend magnitude shifts out of r_quo as quotient bits shift in.
  assign w_shift    = {r_rem, r_quo[WIDTH-1]};
  assign w_diff     = w_shift - {1'b0, w_b_mag};
  assign w_rem_nx   = w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
  assign w_quo_nx   = {r_quo[WIDTH-2:0], ~w_diff[WIDTH]};
  assign w_quo_fix  = (w_a_neg ^ w_b_neg) ? -w_quo_nx : w_quo_nx;
  assign w_rem_fix  = w_a_neg ? -w_rem_nx : w_rem_nx;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // NOTE: a default assignment ahead of the case keeps this block free of inferred latches.
  always_comb begin
    w_next = r_state;
    if (annul_i) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (start_i) w_next = !w_in_div ? S_MUL : (w_in_dbz ? S_DONE : S_DIV);
        S_MUL:  w_next = (r_op[2:1] == 2'b00) ? S_DONE : S_ACC;
        S_ACC:  w_next = S_DONE;
        S_DIV:  if (w_last) w_next = S_DONE;
        S_DONE: w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy_o     = (r_state != S_IDLE) && (r_state != S_DONE);
    done_o     = (r_state == S_DONE);
    whilo_o    = done_o;
    stallreq_o = ((r_state == S_IDLE) & w_accept) | busy_o;
  end

  // NOTE: the datapath is reset along with the FSM because hi_o/lo_o must read zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op   <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_hilo <= '0;
      r_prod <= '0;
      r_rem  <= '0;
      r_quo  <= '0;
      r_cnt  <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_dbz  <= 1'b0;
    end else if (!annul_i) begin
      case (r_state)
        S_IDLE: if (start_i) begin
          r_op   <= op_i;
          r_a    <= opa_i;
          r_b    <= opb_i;
          r_hilo <= hilo_i;
          r_rem  <= '0;
          r_quo  <= w_in_a_mag;
          r_cnt  <= '0;
          if (w_in_div && w_in_dbz) begin
            r_hi  <= opa_i;
            r_lo  <= '1;
            r_dbz <= 1'b1;
          end
        end
        S_MUL: begin
          r_prod <= w_prod;
          if (r_op[2:1] == 2'b00) begin
            {r_hi, r_lo} <= w_prod;
            r_dbz        <= 1'b0;
          end
        end
        S_ACC: begin
          {r_hi, r_lo} <= w_acc;
          r_dbz        <= 1'b0;
        end
        S_DIV: begin
          r_rem <= w_rem_nx;
          r_quo <= w_quo_nx;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_hi  <= w_rem_fix;
            r_lo  <= w_quo_fix;
            r_dbz <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign hi_o          = r_hi;
  assign lo_o          = r_lo;
  assign div_by_zero_o = r_dbz;

endmodule
